// File: rtl/tlul_host_arbiter_pkg.sv
// Shared constants and helpers for the M:1 host arbiter.
package tlul_host_arbiter_pkg;

  // Default outstanding-request bound used by crossbar instances.
  localparam int ARB_MAX_OUT = 4;

  // Host index width; a single host still needs one bit.
  function automatic int idx_w(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/tlul_pkg.sv
// Minimal TL-UL channel types shared by crossbar blocks.
package tlul_pkg;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_arb_id_fifo.sv
// In-order FIFO of granted host indices, one entry per accepted request.
module tlul_arb_id_fifo #(
  parameter  int Depth = 4,
  parameter  int Width = 1,
  localparam int PtrW  = $clog2(Depth),
  localparam int CntW  = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CntW-1:0]  count
);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wptr, rptr;
  logic             do_push, do_pop;

  assign full    = (count == CntW'(Depth));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rptr];

  // Pointers wrap naturally since Depth is a power of two; count only moves on push xor pop.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: entries are only read while count is non-zero.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/tlul_host_arbiter.sv
// M:1 TL-UL arbiter: round-robin A-channel grant held until accept,
// in-order D-channel routing through a host-index FIFO.
module tlul_host_arbiter
  import tlul_pkg::*;
  import tlul_host_arbiter_pkg::*;
#(
  parameter int M      = 2,
  parameter int MaxOut = ARB_MAX_OUT,
  parameter int IdxW   = idx_w(M),
  parameter int CntW   = $clog2(MaxOut + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  tl_h2d_t         tl_h_i [M],
  output tl_d2h_t         tl_h_o [M],
  output tl_h2d_t         tl_d_o,
  input  tl_d2h_t         tl_d_i,
  output logic            idle_o,
  output logic            unexp_rsp_o,
  output logic [CntW-1:0] outstanding_o
);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(M - 1);

  logic [IdxW-1:0] rr_ptr, lock_idx, gnt, head, cand;
  logic            lock, full, empty, accept, pop;
  int              s;

  // Grant: hold the locked host, else first valid host scanning from rr_ptr.
  always_comb begin
    gnt  = rr_ptr;
    s    = 0;
    cand = '0;
    if (lock) begin
      gnt = lock_idx;
    end else begin
      // Walk backwards so the nearest valid host to rr_ptr is assigned last.
      for (int k = M - 1; k >= 0; k--) begin
        s = int'(rr_ptr) + k;
        if (s >= M) s = s - M;
        cand = IdxW'(s);
        if (tl_h_i[cand].a_valid) gnt = cand;
      end
    end
  end

  // Steer the granted request down and the device response up to the FIFO head.
  always_comb begin
    tl_d_o         = tl_h_i[gnt];
    tl_d_o.a_valid = tl_h_i[gnt].a_valid & ~full;
    // With nothing outstanding, stray responses are sunk rather than stalled.
    tl_d_o.d_ready = empty ? 1'b1 : tl_h_i[head].d_ready;
    for (int i = 0; i < M; i++) begin
      tl_h_o[i]         = tl_d_i;
      tl_h_o[i].a_ready = 1'b0;
      tl_h_o[i].d_valid = 1'b0;
    end
    tl_h_o[gnt].a_ready = tl_d_i.a_ready & ~full;
    if (!empty) tl_h_o[head].d_valid = tl_d_i.d_valid;
  end

  assign accept      = tl_d_o.a_valid & tl_d_i.a_ready;
  assign pop         = tl_d_i.d_valid & tl_d_o.d_ready & ~empty;
  assign unexp_rsp_o = tl_d_i.d_valid & empty;
  assign idle_o      = ~lock & (outstanding_o == '0);

  // Advance round-robin on accept; lock the grant while a presented beat stalls.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr   <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
    end else if (accept) begin
      rr_ptr <= (gnt == LastIdx) ? '0 : gnt + 1'b1;
      lock   <= 1'b0;
    end else if (tl_d_o.a_valid) begin
      lock     <= 1'b1;
      lock_idx <= gnt;
    end
  end

  tlul_arb_id_fifo #(
    .Depth (MaxOut),
    .Width (IdxW)
  ) u_id_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (accept),
    .wdata  (gnt),
    .pop    (pop),
    .head   (head),
    .full   (full),
    .empty  (empty),
    .count  (outstanding_o)
  );

endmodule

// File: tb/tb_tlul_host_arbiter.sv
// Directed bench for tlul_host_arbiter (M=2, MaxOut=4) with a queue-based reference model.
module tb_tlul_host_arbiter;
  import tlul_pkg::*;

  localparam int M    = 2;
  localparam int MAXO = 4;

  logic    clk = 1'b0;
  logic    rst_n = 1'b0;
  tl_h2d_t tl_h_i [M];
  tl_d2h_t tl_h_o [M];
  tl_h2d_t tl_d_o;
  tl_d2h_t tl_d_i;
  logic    idle, unexp;
  logic [2:0] outst;

  // Stimulus knobs
  logic        h_av   [M];
  logic [31:0] h_addr [M];
  logic        h_dr   [M];
  logic        dev_ar, dev_dv;
  logic [31:0] dev_data;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int q[$];
  int nxt = 0;
  bit pend = 0;
  int pend_h = 0;
  int dut_log[$];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < M; i++) begin
      tl_h_i[i]           = '0;
      tl_h_i[i].a_valid   = h_av[i];
      tl_h_i[i].a_opcode  = 3'd4;
      tl_h_i[i].a_source  = 8'(i);
      tl_h_i[i].a_mask    = 4'hf;
      tl_h_i[i].a_address = h_addr[i];
      tl_h_i[i].d_ready   = h_dr[i];
    end
    tl_d_i          = '0;
    tl_d_i.a_ready  = dev_ar;
    tl_d_i.d_valid  = dev_dv;
    tl_d_i.d_opcode = 3'd1;
    tl_d_i.d_data   = dev_data;
  end

  tlul_host_arbiter #(.M(M), .MaxOut(MAXO)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .tl_h_i        (tl_h_i),
    .tl_h_o        (tl_h_o),
    .tl_d_o        (tl_d_o),
    .tl_d_i        (tl_d_i),
    .idle_o        (idle),
    .unexp_rsp_o   (unexp),
    .outstanding_o (outst)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic peek();
    @(negedge clk);
  endtask

  // Per-cycle compare against the model, then advance the model at the edge.
  initial begin : cmp
    forever begin
      int  g, c, n, hd;
      bit  full, av_o, acc, pp, edv;
      @(negedge clk);
      n = q.size();
      hd = (n > 0) ? q[0] : -1;
      full = (n == MAXO);
      g = -1;
      if (pend) g = pend_h;
      else begin
        for (int k = 0; k < M; k++) begin
          c = (nxt + k) % M;
          if (g < 0 && h_av[c]) g = c;
        end
      end
      av_o = (g >= 0) && !full;
      chk("m_a_valid", 32'(tl_d_o.a_valid), 32'(av_o));
      if (av_o) chk("m_a_address", tl_d_o.a_address, h_addr[g]);
      for (int h = 0; h < M; h++) begin
        if (full) chk("m_a_ready_full", 32'(tl_h_o[h].a_ready), 32'd0);
        else if (h_av[h]) chk("m_a_ready", 32'(tl_h_o[h].a_ready), 32'((h == g) && dev_ar));
        edv = (hd == h) && dev_dv;
        chk("m_d_valid", 32'(tl_h_o[h].d_valid), 32'(edv));
        if (edv) chk("m_d_data", tl_h_o[h].d_data, dev_data);
      end
      chk("m_d_ready", 32'(tl_d_o.d_ready), 32'((n == 0) ? 1'b1 : h_dr[hd]));
      chk("m_unexp", 32'(unexp), 32'(dev_dv && n == 0));
      chk("m_outstanding", 32'(outst), 32'(n));
      chk("m_idle", 32'(idle), 32'(!pend && n == 0));
      if (tl_d_o.a_valid && dev_ar)
        for (int h = 0; h < M; h++) if (tl_h_o[h].a_ready) dut_log.push_back(h);
      acc = av_o && dev_ar;
      pp  = (n > 0) && dev_dv && h_dr[hd];
      @(posedge clk);
      if (!rst_n) begin
        q.delete();
        nxt = 0;
        pend = 0;
        pend_h = 0;
      end else begin
        if (pp) void'(q.pop_front());
        if (acc) begin
          q.push_back(g);
          nxt = (g + 1) % M;
          pend = 0;
        end else if (av_o) begin
          pend = 1;
          pend_h = g;
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : drive
    int exp_seq [8];
    int n0;
    exp_seq = '{1, 0, 1, 0, 1, 0, 1, 0};
    for (int i = 0; i < M; i++) begin
      h_av[i] = 1'b0; h_addr[i] = '0; h_dr[i] = 1'b1;
    end
    dev_ar = 1'b0; dev_dv = 1'b0; dev_data = '0;

    // Reset state
    tick(); tick();
    peek();
    chk("rst_outstanding", 32'(outst), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_unexp", 32'(unexp), 32'd0);
    chk("rst_a_valid", 32'(tl_d_o.a_valid), 32'd0);
    chk("rst_a_ready0", 32'(tl_h_o[0].a_ready), 32'd0);
    chk("rst_d_valid0", 32'(tl_h_o[0].d_valid), 32'd0);
    tick();
    rst_n = 1'b1;

    // Single host Get
    h_av[0] = 1'b1; h_addr[0] = 32'h1000_0000; dev_ar = 1'b1;
    peek();
    chk("t1_a_valid", 32'(tl_d_o.a_valid), 32'd1);
    chk("t1_addr", tl_d_o.a_address, 32'h1000_0000);
    chk("t1_a_ready0", 32'(tl_h_o[0].a_ready), 32'd1);
    tick();
    h_av[0] = 1'b0; dev_ar = 1'b0;
    peek();
    chk("t1_out_1", 32'(outst), 32'd1);
    chk("t1_idle_0", 32'(idle), 32'd0);
    tick();
    dev_dv = 1'b1; dev_data = 32'hCAFE_0001;
    peek();
    chk("t1_d_valid0", 32'(tl_h_o[0].d_valid), 32'd1);
    chk("t1_d_data0", tl_h_o[0].d_data, 32'hCAFE_0001);
    chk("t1_d_valid1", 32'(tl_h_o[1].d_valid), 32'd0);
    tick();
    dev_dv = 1'b0;
    peek();
    chk("t1_out_0", 32'(outst), 32'd0);
    chk("t1_idle_1", 32'(idle), 32'd1);
    tick();

    // Fairness: both hosts always valid, device always ready
    dut_log.delete();
    h_av[0] = 1'b1; h_addr[0] = 32'h1000_0100;
    h_av[1] = 1'b1; h_addr[1] = 32'h2000_0100;
    dev_ar = 1'b1; dev_data = 32'h0000_FA1E;
    for (int i = 0; i < 8; i++) begin
      peek();
      tick();
      if (i == 0) dev_dv = 1'b1;
    end
    h_av[0] = 1'b0; h_av[1] = 1'b0;
    peek();
    tick();
    dev_dv = 1'b0;
    chk("t2_accepts", 32'(dut_log.size()), 32'd8);
    n0 = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < dut_log.size()) begin
        chk("t2_grant_seq", 32'(dut_log[i]), 32'(exp_seq[i]));
        if (dut_log[i] == 0) n0++;
      end
    end
    chk("t2_host0_accepts", 32'(n0), 32'd4);

    // Lock: host0 stalls while host1 (favoured by round-robin) waits
    h_av[0] = 1'b1; h_addr[0] = 32'h3000_0000; dev_ar = 1'b0;
    peek();
    chk("t3_addr_first", tl_d_o.a_address, 32'h3000_0000);
    tick();
    h_av[1] = 1'b1; h_addr[1] = 32'h2000_0010;
    for (int i = 0; i < 3; i++) begin
      peek();
      chk("t3_hold_addr", tl_d_o.a_address, 32'h3000_0000);
      chk("t3_hold_ardy1", 32'(tl_h_o[1].a_ready), 32'd0);
      tick();
    end
    dev_ar = 1'b1;
    peek();
    chk("t3_rel_addr", tl_d_o.a_address, 32'h3000_0000);
    chk("t3_rel_ardy0", 32'(tl_h_o[0].a_ready), 32'd1);
    chk("t3_rel_ardy1", 32'(tl_h_o[1].a_ready), 32'd0);
    tick();
    h_av[0] = 1'b0;
    peek();
    chk("t3_next_addr", tl_d_o.a_address, 32'h2000_0010);
    chk("t3_next_ardy1", 32'(tl_h_o[1].a_ready), 32'd1);
    tick();
    h_av[1] = 1'b0; dev_ar = 1'b0; dev_dv = 1'b1; dev_data = 32'h0000_00D0;
    peek();
    chk("t3_rsp0_h0", 32'(tl_h_o[0].d_valid), 32'd1);
    chk("t3_rsp0_h1", 32'(tl_h_o[1].d_valid), 32'd0);
    tick();
    dev_data = 32'h0000_00D1;
    peek();
    chk("t3_rsp1_h1", 32'(tl_h_o[1].d_valid), 32'd1);
    chk("t3_rsp1_h0", 32'(tl_h_o[0].d_valid), 32'd0);
    chk("t3_rsp1_data", tl_h_o[1].d_data, 32'h0000_00D1);
    tick();
    dev_dv = 1'b0;

    // Full: four accepts with no responses
    h_av[0] = 1'b1; h_addr[0] = 32'h4000_0000; dev_ar = 1'b1;
    repeat (4) begin peek(); tick(); end
    peek();
    chk("t4_full_count", 32'(outst), 32'd4);
    chk("t4_full_ardy0", 32'(tl_h_o[0].a_ready), 32'd0);
    chk("t4_full_avalid", 32'(tl_d_o.a_valid), 32'd0);
    tick();
    dev_dv = 1'b1; dev_data = 32'h0000_0F00;
    peek();
    chk("t4_pop_dvalid0", 32'(tl_h_o[0].d_valid), 32'd1);
    chk("t4_no_bypass", 32'(tl_h_o[0].a_ready), 32'd0);
    tick();
    dev_dv = 1'b0;
    peek();
    chk("t4_after_pop", 32'(outst), 32'd3);
    chk("t4_ardy_back", 32'(tl_h_o[0].a_ready), 32'd1);
    tick();
    peek();
    chk("t4_refull", 32'(outst), 32'd4);
    tick();
    h_av[0] = 1'b0; h_dr[0] = 1'b0; dev_dv = 1'b1;
    peek();
    chk("t4_bp_dready", 32'(tl_d_o.d_ready), 32'd0);
    tick();
    h_dr[0] = 1'b1;
    peek();
    chk("t4_bp_hold", 32'(outst), 32'd4);
    tick();
    repeat (3) begin peek(); tick(); end
    dev_dv = 1'b0;
    peek();
    chk("t4_drained", 32'(outst), 32'd0);
    tick();

    // Ordering with a coincident push and pop
    h_av[0] = 1'b1; h_addr[0] = 32'h5000_0000; dev_ar = 1'b1;
    peek();
    chk("t5_o0_ardy0", 32'(tl_h_o[0].a_ready), 32'd1);
    tick();
    h_av[0] = 1'b0; h_av[1] = 1'b1; h_addr[1] = 32'h5000_0100; dev_dv = 1'b1;
    peek();
    chk("t5_o1_dvalid0", 32'(tl_h_o[0].d_valid), 32'd1);
    chk("t5_o1_ardy1", 32'(tl_h_o[1].a_ready), 32'd1);
    chk("t5_o1_count", 32'(outst), 32'd1);
    tick();
    h_av[1] = 1'b0; h_av[0] = 1'b1;
    peek();
    chk("t5_o2_count", 32'(outst), 32'd1);
    chk("t5_o2_dvalid1", 32'(tl_h_o[1].d_valid), 32'd1);
    chk("t5_o2_dvalid0", 32'(tl_h_o[0].d_valid), 32'd0);
    tick();
    h_av[0] = 1'b0;
    peek();
    chk("t5_o3_count", 32'(outst), 32'd1);
    chk("t5_o3_dvalid0", 32'(tl_h_o[0].d_valid), 32'd1);
    tick();
    dev_dv = 1'b0;
    peek();
    chk("t5_done", 32'(outst), 32'd0);
    tick();

    // Stray response with empty FIFO
    dev_dv = 1'b1; dev_data = 32'h0000_0BAD; dev_ar = 1'b0;
    peek();
    chk("t6_unexp", 32'(unexp), 32'd1);
    chk("t6_dready", 32'(tl_d_o.d_ready), 32'd1);
    chk("t6_dvalid0", 32'(tl_h_o[0].d_valid), 32'd0);
    chk("t6_dvalid1", 32'(tl_h_o[1].d_valid), 32'd0);
    tick();
    dev_dv = 1'b0;
    peek();
    chk("t6_unexp_clr", 32'(unexp), 32'd0);
    tick();

    // Reset with two outstanding
    h_av[0] = 1'b1; h_addr[0] = 32'h6000_0000; dev_ar = 1'b1;
    peek(); tick();
    peek(); tick();
    h_av[0] = 1'b0; dev_ar = 1'b0;
    peek();
    chk("t7_two_out", 32'(outst), 32'd2);
    tick();
    rst_n = 1'b0;
    tick();
    peek();
    chk("t7_rst_count", 32'(outst), 32'd0);
    chk("t7_rst_idle", 32'(idle), 32'd1);
    tick();
    rst_n = 1'b1;
    peek();
    chk("t7_post_count", 32'(outst), 32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
